// File: rtl/intr_ctrl_pkg.sv
// Shared types and constants for the parameterised interrupt controller:
// FSM state encoding, config-word field positions and trigger-mode values.
package intr_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_ARB   = 3'b010,
    ST_GRANT = 3'b100
  } state_e;

  localparam logic MODE_LEVEL = 1'b0;
  localparam logic MODE_EDGE  = 1'b1;

  // Config word is {mode, enable, priority}; positions scale with the priority width.
  function automatic int unsigned cfg_en_pos(input int unsigned prio_w);
    return prio_w;
  endfunction

  function automatic int unsigned cfg_mode_pos(input int unsigned prio_w);
    return prio_w + 32'd1;
  endfunction

endpackage

// File: rtl/intr_prio_arb.sv
// Combinational priority arbiter: highest priority eligible source wins,
// equal priorities resolve to the lowest index.
module intr_prio_arb #(
  parameter  int NUM_INTR = 16,
  parameter  int PRIO_W   = 4,
  localparam int AW       = $clog2(NUM_INTR)
) (
  input  logic [NUM_INTR-1:0]             elig_i,
  input  logic [NUM_INTR-1:0][PRIO_W-1:0] prio_i,
  output logic [AW-1:0]                   win_idx_o,
  output logic [PRIO_W-1:0]               win_prio_o,
  output logic                            win_any_o
);

  logic take_s;

  // Scan from the top index down so a later (lower) index wins on a tie.
  always_comb begin
    win_idx_o  = '0;
    win_prio_o = '0;
    win_any_o  = 1'b0;
    take_s     = 1'b0;
    for (int i = NUM_INTR - 1; i >= 0; i--) begin
      take_s     = elig_i[i] & (~win_any_o | (prio_i[i] >= win_prio_o));
      win_idx_o  = take_s ? AW'(i) : win_idx_o;
      win_prio_o = take_s ? prio_i[i] : win_prio_o;
      win_any_o  = win_any_o | take_s;
    end
  end

endmodule

// File: rtl/intr_ctrl_param.sv
// Parameterised interrupt controller: per-source config registers behind a
// simple register port, level/edge capture and a three-state grant FSM.
module intr_ctrl_param
  import intr_ctrl_pkg::*;
#(
  parameter  int NUM_INTR = 16,
  parameter  int PRIO_W   = 4,
  localparam int AW       = $clog2(NUM_INTR),
  localparam int CFG_W    = PRIO_W + 2
) (
  input  logic                pclk_i,
  input  logic                prst_i,
  input  logic [AW-1:0]       paddr_i,
  input  logic [CFG_W-1:0]    pwdata_i,
  output logic [CFG_W-1:0]    prdata_o,
  input  logic                penable_i,
  input  logic                pwrite_i,
  output logic                pready_o,
  input  logic [NUM_INTR-1:0] intr_active_i,
  output logic [AW-1:0]       intr_to_service_o,
  output logic [PRIO_W-1:0]   intr_prio_o,
  output logic                intr_valid_o,
  input  logic                intr_serviced_i
);

  logic [CFG_W-1:0]             cfg_q [NUM_INTR];
  logic [CFG_W-1:0]             cfg_d [NUM_INTR];
  logic [CFG_W-1:0]             prdata_q, prdata_d;
  logic                         pready_q;
  logic                         addr_ok_s, wr_s, rd_s, ack_s;
  logic [NUM_INTR-1:0]          en_s, edge_s, rise_s, clr_s, elig_s;
  logic [NUM_INTR-1:0]          prev_q, pending_q, pending_d;
  logic [NUM_INTR-1:0][PRIO_W-1:0] prio_s;
  logic [AW-1:0]                win_idx_s;
  logic [PRIO_W-1:0]            win_prio_s;
  logic                         win_any_s;
  state_e                       state_q, state_d;
  logic [AW-1:0]                svc_q, svc_d;
  logic [PRIO_W-1:0]            prio_q, prio_d;
  logic                         valid_q, valid_d;

  assign addr_ok_s = ({1'b0, paddr_i} < (AW + 1)'(NUM_INTR));
  assign wr_s      = penable_i & pwrite_i & addr_ok_s;
  assign rd_s      = penable_i & ~pwrite_i;
  assign ack_s     = (state_q == ST_GRANT) & intr_serviced_i;

  // Config write decode and read-data capture.
  always_comb begin
    cfg_d = cfg_q;
    for (int i = 0; i < NUM_INTR; i++) begin
      if (wr_s && (paddr_i == AW'(i))) begin
        cfg_d[i] = pwdata_i;
      end else begin
        cfg_d[i] = cfg_q[i];
      end
    end
    if (rd_s) begin
      prdata_d = addr_ok_s ? cfg_q[paddr_i] : '0;
    end else begin
      prdata_d = prdata_q;
    end
  end

  // Field decode, edge capture and eligibility per source.
  always_comb begin
    for (int i = 0; i < NUM_INTR; i++) begin
      prio_s[i] = cfg_q[i][PRIO_W-1:0];
      en_s[i]   = cfg_q[i][cfg_en_pos(PRIO_W)];
      edge_s[i] = (cfg_q[i][cfg_mode_pos(PRIO_W)] == MODE_EDGE);
      clr_s[i]  = ack_s & (svc_q == AW'(i));
    end
    rise_s    = intr_active_i & ~prev_q;
    // A new rising edge outranks the service clear of the same source.
    pending_d = (pending_q & ~clr_s) | (rise_s & edge_s);
    elig_s    = en_s & ((edge_s & pending_q) | (~edge_s & intr_active_i));
  end

  intr_prio_arb #(
    .NUM_INTR (NUM_INTR),
    .PRIO_W   (PRIO_W)
  ) u_arb (
    .elig_i     (elig_s),
    .prio_i     (prio_s),
    .win_idx_o  (win_idx_s),
    .win_prio_o (win_prio_s),
    .win_any_o  (win_any_s)
  );

  // Grant FSM next state and grant output values.
  always_comb begin
    state_d = state_q;
    svc_d   = svc_q;
    prio_d  = prio_q;
    valid_d = valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any_s) begin
          state_d = ST_ARB;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARB: begin
        if (win_any_s) begin
          state_d = ST_GRANT;
          svc_d   = win_idx_s;
          prio_d  = win_prio_s;
          valid_d = 1'b1;
        end else begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (intr_serviced_i) begin
          state_d = ST_IDLE;
          svc_d   = '0;
          prio_d  = '0;
          valid_d = 1'b0;
        end else begin
          state_d = ST_GRANT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        svc_d   = '0;
        prio_d  = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // Register port state.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      for (int i = 0; i < NUM_INTR; i++) begin
        cfg_q[i] <= '0;
      end
      prdata_q <= '0;
      pready_q <= 1'b0;
    end else begin
      cfg_q    <= cfg_d;
      prdata_q <= prdata_d;
      pready_q <= penable_i;
    end
  end

  // Input history and edge-pending flags.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      prev_q    <= '0;
      pending_q <= '0;
    end else begin
      prev_q    <= intr_active_i;
      pending_q <= pending_d;
    end
  end

  // FSM state and grant outputs.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q <= ST_IDLE;
      svc_q   <= '0;
      prio_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      svc_q   <= svc_d;
      prio_q  <= prio_d;
      valid_q <= valid_d;
    end
  end

  assign prdata_o          = prdata_q;
  assign pready_o          = pready_q;
  assign intr_to_service_o = svc_q;
  assign intr_prio_o       = prio_q;
  assign intr_valid_o      = valid_q;

endmodule

// File: tb/tb_intr_ctrl_param.sv
// Self-checking bench for intr_ctrl_param: expected grants are queued as
// stimulus is applied and compared when intr_valid_o rises.
module tb_intr_ctrl_param;

  localparam int NUM_INTR = 12;
  localparam int PRIO_W   = 4;
  localparam int AW       = 4;
  localparam int CFG_W    = 6;

  logic                pclk;
  logic                prst;
  logic [AW-1:0]       paddr;
  logic [CFG_W-1:0]    pwdata;
  logic [CFG_W-1:0]    prdata;
  logic                penable;
  logic                pwrite;
  logic                pready;
  logic [NUM_INTR-1:0] intr_active;
  logic [AW-1:0]       svc;
  logic [PRIO_W-1:0]   prio;
  logic                valid;
  logic                serviced;

  typedef struct packed {
    logic [AW-1:0]     idx;
    logic [PRIO_W-1:0] prio;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic valid_prev = 1'b0;

  intr_ctrl_param #(
    .NUM_INTR (NUM_INTR),
    .PRIO_W   (PRIO_W)
  ) dut (
    .pclk_i            (pclk),
    .prst_i            (prst),
    .paddr_i           (paddr),
    .pwdata_i          (pwdata),
    .prdata_o          (prdata),
    .penable_i         (penable),
    .pwrite_i          (pwrite),
    .pready_o          (pready),
    .intr_active_i     (intr_active),
    .intr_to_service_o (svc),
    .intr_prio_o       (prio),
    .intr_valid_o      (valid),
    .intr_serviced_i   (serviced)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge pclk);
      #1;
    end
  endtask

  task automatic reg_write(input logic [AW-1:0] a, input logic [CFG_W-1:0] d);
    paddr = a; pwdata = d; pwrite = 1'b1; penable = 1'b1;
    cyc(1);
    check_val("wr_pready", 64'(pready), 64'(1));
    penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [AW-1:0] a, input logic [CFG_W-1:0] exp);
    paddr = a; pwrite = 1'b0; penable = 1'b1;
    cyc(1);
    check_val({tag, "_pready"}, 64'(pready), 64'(1));
    check_val(tag, 64'(prdata), 64'(exp));
    penable = 1'b0;
  endtask

  task automatic push_exp(input logic [AW-1:0] i, input logic [PRIO_W-1:0] p);
    exp_t e;
    e.idx  = i;
    e.prio = p;
    sb_q.push_back(e);
  endtask

  task automatic wait_grant(input string tag, output int cycles);
    cycles = 0;
    while (!valid && cycles < 50) begin
      cyc(1);
      cycles++;
    end
    check_val(tag, 64'(valid), 64'(1));
  endtask

  task automatic ack();
    serviced = 1'b1;
    cyc(1);
    serviced = 1'b0;
  endtask

  task automatic check_idle(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      cyc(1);
      if (valid) seen++;
    end
    check_val(tag, 64'(seen), 64'(0));
  endtask

  // Scoreboard: each new grant must match the oldest queued expectation.
  always @(negedge pclk) begin
    if (valid && !valid_prev) begin
      if (sb_q.size() > 0) begin
        check_val("grant_idx", 64'(svc), 64'(sb_q[0].idx));
        check_val("grant_prio", 64'(prio), 64'(sb_q[0].prio));
        void'(sb_q.pop_front());
      end else begin
        check_val("unexpected_grant", 64'(1), 64'(0));
      end
    end
    valid_prev <= valid;
  end

  initial begin
    int lat;
    prst = 1'b1; paddr = '0; pwdata = '0; penable = 1'b0; pwrite = 1'b0;
    intr_active = '0; serviced = 1'b0;
    cyc(2);
    check_val("rst_valid", 64'(valid), 64'(0));
    check_val("rst_svc", 64'(svc), 64'(0));
    check_val("rst_prio", 64'(prio), 64'(0));
    check_val("rst_pready", 64'(pready), 64'(0));
    check_val("rst_prdata", 64'(prdata), 64'(0));
    prst = 1'b0;
    cyc(1);

    // Two level sources, higher priority wins; then the remaining one.
    reg_write(4'd3, 6'b01_0101);
    reg_write(4'd9, 6'b01_1100);
    push_exp(4'd9, 4'd12);
    intr_active[3] = 1'b1; intr_active[9] = 1'b1;
    wait_grant("grant_9", lat);
    check_val("latency", 64'(lat), 64'(2));
    intr_active[9] = 1'b0;
    reg_write(4'd9, 6'b00_0001);
    cyc(3);
    check_val("hold_valid", 64'(valid), 64'(1));
    check_val("hold_svc", 64'(svc), 64'(9));
    check_val("hold_prio", 64'(prio), 64'(12));
    push_exp(4'd3, 4'd5);
    ack();
    check_val("ack_valid", 64'(valid), 64'(0));
    check_val("ack_svc", 64'(svc), 64'(0));
    check_val("ack_prio", 64'(prio), 64'(0));
    wait_grant("grant_3", lat);
    check_val("gap", 64'(lat), 64'(2));
    intr_active[3] = 1'b0;
    ack();
    reg_write(4'd9, 6'b01_1100);
    check_idle("idle_after_3", 5);

    // Equal priorities resolve to the lowest index.
    reg_write(4'd2, 6'b01_0111);
    reg_write(4'd6, 6'b01_0111);
    push_exp(4'd2, 4'd7);
    push_exp(4'd6, 4'd7);
    intr_active[2] = 1'b1; intr_active[6] = 1'b1;
    wait_grant("grant_2", lat);
    intr_active[2] = 1'b0;
    ack();
    wait_grant("grant_6", lat);
    intr_active[6] = 1'b0;
    ack();
    check_idle("idle_after_6", 5);

    // Edge source: one-cycle pulse, no re-grant, re-raise during ack.
    reg_write(4'd5, 6'b11_0011);
    push_exp(4'd5, 4'd3);
    intr_active[5] = 1'b1;
    cyc(1);
    intr_active[5] = 1'b0;
    wait_grant("grant_5a", lat);
    ack();
    check_idle("no_regrant_5", 6);
    push_exp(4'd5, 4'd3);
    intr_active[5] = 1'b1; serviced = 1'b1;
    cyc(1);
    intr_active[5] = 1'b0;
    cyc(1);
    serviced = 1'b0;
    wait_grant("grant_5b", lat);
    push_exp(4'd5, 4'd3);
    intr_active[5] = 1'b1; serviced = 1'b1;
    cyc(1);
    intr_active[5] = 1'b0; serviced = 1'b0;
    wait_grant("grant_5c", lat);
    ack();
    check_idle("idle_after_5", 5);

    // Disabled source never wins until enabled.
    reg_write(4'd4, 6'b00_1001);
    intr_active[4] = 1'b1;
    check_idle("disabled_4", 20);
    push_exp(4'd4, 4'd9);
    reg_write(4'd4, 6'b01_1001);
    wait_grant("grant_4", lat);
    intr_active[4] = 1'b0;
    ack();

    // Register reads, including out-of-range address and hold.
    reg_read("rd_oob", 4'd12, 6'b00_0000);
    reg_read("rd_cfg9", 4'd9, 6'b01_1100);
    reg_read("rd_cfg5", 4'd5, 6'b11_0011);
    cyc(1);
    check_val("idle_pready", 64'(pready), 64'(0));
    check_val("prdata_hold", 64'(prdata), 64'(6'b11_0011));

    // Reset in the middle of a grant.
    push_exp(4'd9, 4'd12);
    intr_active[9] = 1'b1;
    wait_grant("grant_9r", lat);
    paddr = 4'd9; pwrite = 1'b0; penable = 1'b1; prst = 1'b1;
    cyc(1);
    check_val("rst_g_valid", 64'(valid), 64'(0));
    check_val("rst_g_svc", 64'(svc), 64'(0));
    check_val("rst_g_prio", 64'(prio), 64'(0));
    check_val("rst_g_pready", 64'(pready), 64'(0));
    check_val("rst_g_prdata", 64'(prdata), 64'(0));
    prst = 1'b0; penable = 1'b0;
    check_idle("cfg_cleared", 6);
    intr_active[9] = 1'b0;
    reg_read("rd_cfg9_rst", 4'd9, 6'b00_0000);
    cyc(2);
    check_val("sb_empty", 64'(sb_q.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_param.md
INTR_CTRL_PARAM -- requirements
Module: intr_ctrl_param

Interface
REQ-001 Parameter NUM_INTR, default 16, number of interrupt sources (2..64).
REQ-002 Parameter PRIO_W, default 4, priority field width in bits.
REQ-003 Derived AW = clog2(NUM_INTR); CFG_W = PRIO_W+2.
REQ-004 pclk_i  in  1  single clock; all logic rising-edge.
REQ-005 prst_i  in  1  reset, synchronous, active-high.
REQ-006 paddr_i  in  AW  config register index.
REQ-007 pwdata_i  in  CFG_W  write data {mode, enable, priority[PRIO_W-1:0]}.
REQ-008 prdata_o  out  CFG_W  registered read data.
REQ-009 penable_i  in  1  access strobe.
REQ-010 pwrite_i  in  1  1 = write, 0 = read.
REQ-011 pready_o  out  1  registered access acknowledge.
REQ-012 intr_active_i  in  NUM_INTR  peripheral request lines.
REQ-013 intr_to_service_o  out  AW  granted interrupt index.
REQ-014 intr_prio_o  out  PRIO_W  priority of granted interrupt.
REQ-015 intr_valid_o  out  1  grant valid.
REQ-016 intr_serviced_i  in  1  processor service-complete acknowledge.

Function
REQ-017 Per-source config register: priority, enable (bit PRIO_W), mode (bit PRIO_W+1: 0 level, 1 rising-edge).
REQ-018 penable_i=1 at edge t: pready_o=1 after t; write updates cfg[paddr_i], read loads prdata_o=cfg[paddr_i]; penable_i=0: pready_o=0, prdata_o holds.
REQ-019 paddr_i >= NUM_INTR: write ignored, read returns 0, pready_o still 1.
REQ-020 Level source eligible while intr_active_i[i]=1 and enable=1.
REQ-021 Edge source: registered previous input; 0->1 sets pending[i]; eligible while pending[i]=1 and enable=1; disabling does not clear pending.
REQ-022 FSM states IDLE, ARB, GRANT; IDLE->ARB when any source eligible, else stay.
REQ-023 ARB (one cycle): winner = eligible source with highest priority, ties to lowest index; register intr_to_service_o, intr_prio_o, intr_valid_o=1; ->GRANT. No eligible source in ARB: ->IDLE, valid stays 0.
REQ-024 GRANT: outputs held stable until intr_serviced_i=1; requests/config changes/deassertion of granted line do not alter grant.
REQ-025 intr_serviced_i=1 in GRANT: next edge intr_valid_o=0, intr_to_service_o=0, intr_prio_o=0, pending[granted] cleared, ->IDLE.
REQ-026 Rising edge on granted edge source in service-ack cycle: pending set wins (re-raised).
REQ-027 intr_serviced_i outside GRANT ignored.
REQ-028 Latency: source eligible at edge t (IDLE) -> intr_valid_o=1 after edge t+2; back-to-back grants separated by >=2 cycles of valid low.
REQ-029 Register writes and arbitration operate concurrently; write in ARB cycle is visible to that ARB only if registered before it.

Reset
REQ-030 prst_i=1 at edge: state=IDLE, all cfg=0 (disabled, level, prio 0), pending=0, edge-history=0, prdata_o=0, pready_o=0, intr_to_service_o=0, intr_prio_o=0, intr_valid_o=0.
REQ-031 Reset mid-GRANT drops grant immediately; no service acknowledge required.

Structure
REQ-032 Package intr_ctrl_pkg: FSM state enum (one-hot), config field bit positions, MODE_LEVEL/MODE_EDGE constants.
REQ-033 Combinational sub-module intr_prio_arb (NUM_INTR, PRIO_W): eligible vector + priorities in, winner index/priority/any out.
REQ-034 Single always-block per register group; no blocking-assignment state updates across blocks.

Verification
REQ-035 Write cfg[3]={0,1,5}, cfg[9]={0,1,12}; raise lines 3 and 9 -> valid after 2 cycles, service_o=9, prio_o=12.
REQ-036 cfg[2]=cfg[6]={0,1,7}, both active -> service_o=2; ack -> valid low, next grant service_o=6.
REQ-037 cfg[5]={1,1,3}; pulse line 5 one cycle -> grant 5; ack -> no re-grant; pulse during ack cycle -> re-grant 5.
REQ-038 Line 4 active with enable=0 -> no grant for 20 cycles; set enable -> grant 4.
REQ-039 Read paddr=NUM_INTR -> prdata_o=0, pready_o=1; read cfg[9] returns {0,1,12}.
REQ-040 prst_i asserted during GRANT -> next edge all outputs 0, cfg cleared, state IDLE.
